// File: rtl/cic_decimator.sv
// Programmable 3-stage CIC decimator (R = 1..16, M = 1) with exact R^3 gain
// normalisation, round-half-up, saturation and a one-cycle registered bypass.
module cic_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int N_STAGES   = 3,
    parameter int MAX_LOG2R  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         filter_enable,
    input  logic [4:0]                   CIC_Decimation_Factor,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         out_valid,
    output logic                         cfg_err
);

    localparam int W   = DATA_WIDTH + N_STAGES * MAX_LOG2R;
    localparam int SW  = $clog2(N_STAGES * MAX_LOG2R + 1);
    localparam int RLW = $clog2(MAX_LOG2R + 1);

    localparam logic signed [W:0] ONE   = 1;
    localparam logic signed [W:0] Y_MAX = (W+1)'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [W:0] Y_MIN = ~Y_MAX;

    // Sign-extend by one bit so the rounding bias can never wrap the sum.
    function automatic logic signed [W:0] round_shift(input logic signed [W-1:0] c,
                                                      input logic [SW-1:0] s);
        logic signed [W:0] acc;
        logic signed [W:0] bias;
        acc  = {c[W-1], c};
        bias = '0;
        if (s != '0) bias = ONE <<< (s - SW'(1));
        return (acc + bias) >>> s;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [W:0] y);
        if (y > Y_MAX) return Y_MAX[DATA_WIDTH-1:0];
        if (y < Y_MIN) return Y_MIN[DATA_WIDTH-1:0];
        return y[DATA_WIDTH-1:0];
    endfunction

    logic [RLW-1:0]               rlog_d, rlog_q;
    logic                         en_q;
    logic                         fact_ok, restart;
    logic [SW-1:0]                shift;
    logic [MAX_LOG2R-1:0]         r_last;

    logic signed [W-1:0]          i1_d, i1_q, i2_d, i2_q, i3_d, i3_q;
    logic [MAX_LOG2R-1:0]         cnt_d, cnt_q;
    logic                         stb_p0_d, stb_p0_q;
    logic signed [W-1:0]          i3_dly_d, i3_dly_q, c1_p1_d, c1_p1_q;
    logic signed [W-1:0]          c1_dly_d, c1_dly_q, c2_p2_d, c2_p2_q;
    logic signed [W-1:0]          c2_dly_d, c2_dly_q, c3_p3_d, c3_p3_q;
    logic                         vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;
    logic signed [DATA_WIDTH-1:0] data_out_d, data_out_q;
    logic                         out_valid_d, out_valid_q;
    logic                         cfg_err_d, cfg_err_q;

    always_comb begin
        rlog_d  = '0;
        fact_ok = 1'b0;
        for (int k = 0; k <= MAX_LOG2R; k++) begin
            if (CIC_Decimation_Factor == 5'(1 << k)) begin
                rlog_d  = RLW'(k);
                fact_ok = 1'b1;
            end
        end
        restart = (rlog_d != rlog_q) || (filter_enable != en_q);
        shift   = SW'(rlog_q) * SW'(N_STAGES);
        r_last  = MAX_LOG2R'((32'd1 << rlog_q) - 32'd1);

        i1_d        = i1_q;
        i2_d        = i2_q;
        i3_d        = i3_q;
        cnt_d       = cnt_q;
        stb_p0_d    = 1'b0;
        i3_dly_d    = i3_dly_q;
        c1_p1_d     = c1_p1_q;
        vld_p1_d    = 1'b0;
        c1_dly_d    = c1_dly_q;
        c2_p2_d     = c2_p2_q;
        vld_p2_d    = 1'b0;
        c2_dly_d    = c2_dly_q;
        c3_p3_d     = c3_p3_q;
        vld_p3_d    = 1'b0;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        cfg_err_d   = ~fact_ok;

        if (restart || !filter_enable) begin
            // Filter state is flushed on restart and parked at zero in bypass.
            i1_d     = '0;
            i2_d     = '0;
            i3_d     = '0;
            cnt_d    = '0;
            i3_dly_d = '0;
            c1_p1_d  = '0;
            c1_dly_d = '0;
            c2_p2_d  = '0;
            c2_dly_d = '0;
            c3_p3_d  = '0;
            if (restart) begin
                data_out_d = '0;
            end else if (in_valid) begin
                data_out_d  = data_in;
                out_valid_d = 1'b1;
            end
        end else begin
            // p0: integrators and decimation counter
            if (in_valid) begin
                i1_d = i1_q + {{(W-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
                i2_d = i2_q + i1_q;
                i3_d = i3_q + i2_q;
                if (cnt_q == r_last) begin
                    cnt_d    = '0;
                    stb_p0_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // p1: first comb
            vld_p1_d = stb_p0_q;
            if (stb_p0_q) begin
                c1_p1_d  = i3_q - i3_dly_q;
                i3_dly_d = i3_q;
            end
            // p2: second comb
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                c2_p2_d  = c1_p1_q - c1_dly_q;
                c1_dly_d = c1_p1_q;
            end
            // p3: third comb
            vld_p3_d = vld_p2_q;
            if (vld_p2_q) begin
                c3_p3_d  = c2_p2_q - c2_dly_q;
                c2_dly_d = c2_p2_q;
            end
            // output: gain normalisation, rounding, saturation
            if (vld_p3_q) begin
                data_out_d  = saturate(round_shift(c3_p3_q, shift));
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // Loaded even during reset so release never looks like a config change.
        rlog_q <= rlog_d;
        en_q   <= filter_enable;
        if (RST) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            cnt_q       <= '0;
            stb_p0_q    <= 1'b0;
            i3_dly_q    <= '0;
            c1_p1_q     <= '0;
            vld_p1_q    <= 1'b0;
            c1_dly_q    <= '0;
            c2_p2_q     <= '0;
            vld_p2_q    <= 1'b0;
            c2_dly_q    <= '0;
            c3_p3_q     <= '0;
            vld_p3_q    <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            cnt_q       <= cnt_d;
            stb_p0_q    <= stb_p0_d;
            i3_dly_q    <= i3_dly_d;
            c1_p1_q     <= c1_p1_d;
            vld_p1_q    <= vld_p1_d;
            c1_dly_q    <= c1_dly_d;
            c2_p2_q     <= c2_p2_d;
            vld_p2_q    <= vld_p2_d;
            c2_dly_q    <= c2_dly_d;
            c3_p3_q     <= c3_p3_d;
            vld_p3_q    <= vld_p3_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed self-checking bench for cic_decimator: reset, DC settle, extremes,
// gapped input against a bit-true model, factor change, illegal factor, bypass.
module tb_cic_decimator;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [4:0]         fac;
    logic               iv;
    logic signed [15:0] din;
    logic signed [15:0] dout;
    logic               ov;
    logic               cerr;

    int checks   = 0;
    int failures = 0;
    int expq[$];

    always #5 clk = ~clk;

    cic_decimator dut (
        .CLK                   (clk),
        .RST                   (rst),
        .filter_enable         (en),
        .CIC_Decimation_Factor (fac),
        .in_valid              (iv),
        .data_in               (din),
        .data_out              (dout),
        .out_valid             (ov),
        .cfg_err               (cerr)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint wrapw(input longint v);
        longint m;
        m = v & ((64'sd1 <<< 28) - 64'sd1);
        if (m[27]) m = m - (64'sd1 <<< 28);
        return m;
    endfunction

    function automatic int model_out(input longint c, input int s);
        longint y;
        y = c;
        if (s > 0) y = y + (64'sd1 <<< (s - 1));
        y = y >>> s;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    initial begin
        int npulse, first, last, bad_gap, bad_val;
        logic signed [15:0] xv;
        longint mi1, mi2, mi3, md1, md2, md3, c1, c2, c3;
        int mcnt, e;
        logic signed [15:0] bv_d[4];
        logic               bv_v[4];
        int                 bv_e[4];

        rst = 1'b1; en = 1'b1; fac = 5'd4; iv = 1'b0; din = '0;
        repeat (3) tick();
        check("reset_dout", dout, 0);
        check("reset_ov", ov, 0);
        check("reset_cfg_err", cerr, 0);

        // DC settle, R = 4
        rst = 1'b0;
        npulse = 0; first = -1; last = -1; bad_gap = 0; bad_val = 0;
        for (int t = 0; t < 404; t++) begin
            iv = (t < 400); din = 16'sd1000;
            tick();
            if (ov) begin
                npulse++;
                if (first < 0) first = t;
                else if (t - last != 4) bad_gap++;
                last = t;
                if (npulse >= 4 && dout != 16'sd1000) bad_val++;
            end
        end
        check("dc_pulses", npulse, 100);
        check("dc_first_pulse_cycle", first, 7);
        check("dc_gap_errors", bad_gap, 0);
        check("dc_value_errors", bad_val, 0);
        check("dc_final", dout, 1000);

        // Reset mid-stream at input 57, R = 4
        for (int t = 0; t < 57; t++) begin
            iv = 1'b1; din = 16'($urandom);
            tick();
        end
        rst = 1'b1; din = 16'($urandom);
        tick();
        check("midrst_dout", dout, 0);
        check("midrst_ov", ov, 0);
        check("midrst_cfg_err", cerr, 0);
        rst = 1'b0;
        first = -1;
        for (int j = 0; j < 8; j++) begin
            din = 16'($urandom);
            tick();
            if (ov && first < 0) first = j;
        end
        check("midrst_first_pulse", first, 7);

        // Factor change 4 -> 8 with a strobe in flight
        rst = 1'b1; iv = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            iv = 1'b1; din = 16'sd500;
            tick();
        end
        fac = 5'd8;
        tick();
        check("r8_restart_ov", ov, 0);
        first = -1;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (ov && first < 0) first = j;
        end
        check("r8_first_pulse", first, 11);

        // Extremes at R = 16: integrators wrap, output settles without saturating
        fac = 5'd16; iv = 1'b0;
        repeat (2) tick();
        for (int ph = 0; ph < 2; ph++) begin
            xv = (ph == 0) ? 16'sh7FFF : 16'sh8000;
            npulse = 0; bad_val = 0;
            for (int t = 0; t < 2006; t++) begin
                iv = (t < 2000); din = xv;
                tick();
                if (ov) begin
                    npulse++;
                    if (npulse >= 4 && dout != xv) bad_val++;
                end
            end
            check(ph == 0 ? "ext_hi_pulses" : "ext_lo_pulses", npulse, 125);
            check(ph == 0 ? "ext_hi_value_errors" : "ext_lo_value_errors", bad_val, 0);
            check(ph == 0 ? "ext_hi_final" : "ext_lo_final", dout, int'(xv));
        end

        // Gapped ramp at R = 2 against a bit-true model
        fac = 5'd2; iv = 1'b0;
        repeat (2) tick();
        mi1 = 0; mi2 = 0; mi3 = 0; md1 = 0; md2 = 0; md3 = 0; mcnt = 0;
        npulse = 0; last = -1; bad_gap = 0;
        for (int t = 0; t < 2008; t++) begin
            iv = (t % 2 == 0) && (t < 2000);
            din = 16'(t / 2);
            if (iv) begin
                mi3 = wrapw(mi3 + mi2);
                mi2 = wrapw(mi2 + mi1);
                mi1 = wrapw(mi1 + longint'(din));
                mcnt++;
                if (mcnt == 2) begin
                    mcnt = 0;
                    c1 = wrapw(mi3 - md1); md1 = mi3;
                    c2 = wrapw(c1 - md2);  md2 = c1;
                    c3 = wrapw(c2 - md3);  md3 = c2;
                    expq.push_back(model_out(c3, 3));
                end
            end
            tick();
            if (ov) begin
                npulse++;
                if (last >= 0 && t - last != 4) bad_gap++;
                last = t;
                e = (expq.size() > 0) ? expq.pop_front() : 99999;
                check("gap_out", dout, e);
            end
        end
        check("gap_pulses", npulse, 500);
        check("gap_spacing_errors", bad_gap, 0);

        // Illegal factor 3 behaves as R = 1
        fac = 5'd3; iv = 1'b0; din = 16'sd700;
        tick();
        check("illegal_cfg_err", cerr, 1);
        tick();
        npulse = 0; first = -1;
        for (int j = 0; j < 20; j++) begin
            iv = 1'b1;
            tick();
            if (ov) begin
                npulse++;
                if (first < 0) first = j;
            end
        end
        check("r1_first_pulse", first, 4);
        check("r1_pulses", npulse, 16);
        check("r1_final", dout, 700);
        check("r1_cfg_err_held", cerr, 1);

        // Bypass
        fac = 5'd16; en = 1'b0; iv = 1'b0;
        tick();
        check("byp_cfg_err_cleared", cerr, 0);
        check("byp_restart_ov", ov, 0);
        bv_d[0] = 16'sh1234; bv_v[0] = 1'b1; bv_e[0] = 4660;
        bv_d[1] = 16'sh8000; bv_v[1] = 1'b1; bv_e[1] = -32768;
        bv_d[2] = 16'sh5555; bv_v[2] = 1'b0; bv_e[2] = -32768;
        bv_d[3] = 16'sh0001; bv_v[3] = 1'b1; bv_e[3] = 1;
        for (int k = 0; k < 4; k++) begin
            din = bv_d[k]; iv = bv_v[k];
            tick();
            check("byp_dout", dout, bv_e[k]);
            check("byp_ov", ov, int'(bv_v[k]));
        end
        fac = 5'd0; iv = 1'b0;
        tick();
        check("byp_cfg_err_live", cerr, 1);
        fac = 5'd16;
        tick();

        // Re-enable: one restart cycle, then R = 16 decimation
        en = 1'b1; iv = 1'b1; din = 16'sd100;
        tick();
        check("reen_restart_ov", ov, 0);
        check("reen_restart_dout", dout, 0);
        first = -1;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (ov && first < 0) first = j;
        end
        check("reen_first_pulse", first, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Programmable 3-stage CIC decimator, the final stage of the DFE chain. It consumes the notch filter output samples, qualified by the notch stage's valid strobe, and decimates by R ∈ {1, 2, 4, 8, 16}, taken from `CIC_Decimation_Factor`. It normalises the R³ gain exactly, then rounds and saturates to `DATA_WIDTH`. When `filter_enable` is low it is a one-cycle registered bypass.

## Interface
- `DATA_WIDTH`, 16, sample width (two's complement) on input and output.
- `N_STAGES`, 3, integrator/comb stage count (fixed; differential delay M = 1).
- `MAX_LOG2R`, 4, log2 of the largest R; internal width W = `DATA_WIDTH` + `N_STAGES`·`MAX_LOG2R` = 28.

Ports:
- `CLK`  in  1  system clock; one clock, single domain.
- `RST`  in  1  synchronous, active-high reset.
- `filter_enable`  in  1  1 = decimate, 0 = bypass.
- `CIC_Decimation_Factor`  in  5  requested R.
- `in_valid`  in  1  `data_in` qualifier; may be high every cycle.
- `data_in`  in  `DATA_WIDTH`  signed input sample.
- `data_out`  out  `DATA_WIDTH`  signed output sample; held between strobes.
- `out_valid`  out  1  one-cycle strobe per output sample.
- `cfg_err`  out  1  high while `CIC_Decimation_Factor` is not a legal R.

## Operation
- Reset clears the following to 0: integrators, comb delays, comb pipeline, decimation counter, `data_out`, `out_valid`, and `cfg_err`.
- Factor decode:
  - Legal values are 1, 2, 4, 8 and 16, giving shift S = 3·log2 R.
  - Any other value, including 0, decodes as R = 1 with `cfg_err` = 1.
  - The decoded R is registered each cycle.
- Integrators, updated only on `in_valid`, all W-bit, wrapping modulo 2^W:
  - I1 <= I1 + sext(`data_in`)
  - I2 <= I2 + I1
  - I3 <= I3 + I2
  - Right-hand sides use pre-edge values.
  - Wrap-around is required behaviour; never saturate internally.
- Decimation counter:
  - Counts accepted samples from 0 to R−1.
  - On the edge accepting sample R−1, it wraps to 0 and sets the internal `dec_stb` for one cycle.
  - For R = 1, every accepted sample produces `dec_stb`.
- Comb pipeline: a valid bit travels with the data, one register per stage.
  - C1 = I3 − I3_d, C2 = C1 − C1_d, C3 = C2 − C2_d, all W-bit modular.
  - Each `_d` register updates only when its stage's valid is high.
- Output stage:
  - Compute y = (C3 + (S > 0 ? 2^(S−1) : 0)) >>> S, which is round-half-up.
  - Saturate y to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] and register it into `data_out`.
  - Pulse `out_valid`.
- Soft restart, a single-cycle clear of the same state as `RST` except `cfg_err`:
  - Triggered when the decoded R changes or `filter_enable` changes.
  - A sample presented in the restart cycle is dropped.
  - Strobes already in the comb pipeline are discarded, so no `out_valid` comes from old state.
- Bypass (`filter_enable` = 0):
  - On `in_valid`, `data_out` <= `data_in`.
  - `out_valid` <= `in_valid`.
  - Integrators and combs are held at 0.
  - `cfg_err` remains live in bypass.

## Timing
- Decimate-mode latency: the edge accepting sample R−1 is E0, and `out_valid` is high in the cycle after E4. The registered path is:
  - `dec_stb` → C1 → C2 → C3 → output register.
- Bypass latency: one clock.
- Throughput: one input per cycle sustained, giving one output per R inputs. The pipeline never stalls and has no backpressure.
- DC gain: R³·2^−S = 1 exactly, so a constant input x settles to x. The first three outputs after a reset or restart are transient.
- `RST` asserted mid-stream: every output is 0 on the following cycle, and no pending `out_valid` survives.
- `in_valid` low: no state advances except the comb pipeline, which drains on its own. `data_out` holds its last value.

## Test plan
- Reset mid-stream: R = 4, random data, assert `RST` for one cycle at input 57 → `data_out` = 0 and `out_valid` = 0 the next cycle. The first output after release comes 4 inputs later.
- DC settle: R = 4, `data_in` = 1000 on every cycle for 400 cycles → exactly 100 `out_valid` pulses. From the 4th pulse onward, `data_out` = 1000. Pulses are 4 cycles apart, and the first arrives 4 cycles after the edge accepting input 3.
- Extremes with wrap: R = 16 and `data_in` = 32767 for 2000 samples → settles at 32767. Repeat with −32768 → settles at −32768. No saturation is hit, so the integrators wrap silently.
- Gapped input: R = 2, `in_valid` high every other cycle, mirroring the chain's input rate, with input 0,1,2,… → one output per 4 clocks. Output matches a golden bit-true model for the first 500 outputs.
- Factor change and illegal value:
  - Switch R from 4 to 8 mid-stream → no output carrying pre-switch state. The next pulse comes 4 cycles after the 8th post-restart sample.
  - Set the factor to 3 → `cfg_err` = 1 and the block behaves as R = 1.
- Bypass: `filter_enable` = 0, `in_valid` every cycle with 0x1234, 0x8000 → `data_out` equals the input one cycle later and `out_valid` mirrors `in_valid`. Re-enable → a one-cycle restart, then normal decimation.
